quad2paddle: RTL and testbench



---
 rtl/quad2paddle_if.sv | 22 ++
 rtl/quad2paddle.sv | 160 ++++++++++++++++
 tb/tb_quad2paddle.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/quad2paddle_if.sv
// Encoder/paddle signal bundle for quad2paddle.
// master drives the encoder phases and center; slave is the decoder.
interface quad2paddle_if;
  logic       enc_a;
  logic       enc_b;
  logic       center;
  logic [7:0] paddle;
  logic       dir;
  logic       step_pulse;
  logic       err;
  logic       active;

  modport master (
    output enc_a, enc_b, center,
    input  paddle, dir, step_pulse, err, active
  );

  modport slave (
    input  enc_a, enc_b, center,
    output paddle, dir, step_pulse, err, active
  );
endinterface

// File: rtl/quad2paddle.sv
// Quadrature decoder: filtered A/B phases -> saturating 8-bit paddle, step/err pulses, activity flag.
// Macro QUAD_X4_EN: count every Gray transition (x4); undefined counts only arrivals at 00 (x1).
module quad2paddle #(
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned STEP     = 2,
  parameter int unsigned CENTER   = 128,
  parameter int unsigned IDLE_CYC = 12000000
) (
  input logic          clk_sys,
  input logic          reset,
  quad2paddle_if.slave bus
);
  localparam int unsigned IDLE_W    = $clog2(IDLE_CYC + 1);
  localparam int unsigned PRIME_CYC = FILT_LEN + 2;

  typedef enum logic {PRIME, RUN} state_e;

  state_e            state_q, state_d;
  logic [1:0]        sync1_q, sync1_d;
  logic [1:0]        sync2_q, sync2_d;
  logic [1:0]        acc_q, acc_d;
  logic [3:0]        cnt_a_q, cnt_a_d;
  logic [3:0]        cnt_b_q, cnt_b_d;
  logic [4:0]        prime_cnt_q, prime_cnt_d;
  logic [1:0]        prev_ab_q, prev_ab_d;
  logic [7:0]        paddle_q, paddle_d;
  logic              dir_q, dir_d;
  logic              step_q, step_d;
  logic              err_q, err_d;
  logic              active_q, active_d;
  logic [IDLE_W-1:0] idle_q, idle_d;

  logic [8:0]        up9, dn9;
  logic [1:0]        delta;
  logic              count_here;

  // Returns {accepted_level, counter} for one channel.
  function automatic logic [4:0] filt_step(input logic synced, input logic accepted,
                                           input logic [3:0] cnt);
    logic [4:0] r;
    r = {accepted, 4'd0};
    if (synced != accepted) begin
      if (cnt == 4'(FILT_LEN - 1)) r = {synced, 4'd0};
      else                         r = {accepted, cnt + 4'd1};
    end
    return r;
  endfunction

  // Maps Gray {a,b} to a 0..3 position so forward rotation is +1 mod 4.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

`ifdef QUAD_X4_EN
  assign count_here = 1'b1;
`else
  assign count_here = (acc_q == 2'b00);
`endif

  always_comb begin
    state_d     = state_q;
    sync1_d     = {bus.enc_a, bus.enc_b};
    sync2_d     = sync1_q;
    acc_d       = acc_q;
    cnt_a_d     = cnt_a_q;
    cnt_b_d     = cnt_b_q;
    prime_cnt_d = prime_cnt_q;
    prev_ab_d   = prev_ab_q;
    paddle_d    = paddle_q;
    dir_d       = dir_q;
    step_d      = 1'b0;
    err_d       = 1'b0;
    idle_d      = idle_q;
    active_d    = active_q;
    up9         = {1'b0, paddle_q} + 9'(STEP);
    dn9         = {1'b0, paddle_q} - 9'(STEP);
    delta       = gray_pos(acc_q) - gray_pos(prev_ab_q);

    case (state_q)
      PRIME: begin
        // The accepted register doubles as the stability reference; the two
        // extra cycles let the synchronizer flush its reset values first.
        acc_d = sync2_q;
        if (sync2_q != acc_q) begin
          prime_cnt_d = '0;
        end else if (prime_cnt_q == 5'(PRIME_CYC - 1)) begin
          state_d     = RUN;
          prev_ab_d   = sync2_q;
          prime_cnt_d = '0;
        end else begin
          prime_cnt_d = prime_cnt_q + 5'd1;
        end
      end
      RUN: begin
        {acc_d[1], cnt_a_d} = filt_step(sync2_q[1], acc_q[1], cnt_a_q);
        {acc_d[0], cnt_b_d} = filt_step(sync2_q[0], acc_q[0], cnt_b_q);
        prev_ab_d = acc_q;
        if (delta == 2'd2) begin
          err_d = 1'b1;
        end else if (delta != 2'd0 && count_here) begin
          step_d = 1'b1;
          dir_d  = (delta == 2'd1);
          if (delta == 2'd1) paddle_d = up9[8] ? 8'hFF : up9[7:0];
          else               paddle_d = dn9[8] ? 8'h00 : dn9[7:0];
        end
      end
      default: state_d = PRIME;
    endcase

    if (bus.center) paddle_d = 8'(CENTER);

    if (step_d) begin
      idle_d   = '0;
      active_d = 1'b1;
    end else begin
      if (idle_q != IDLE_W'(IDLE_CYC)) idle_d = idle_q + IDLE_W'(1);
      if (idle_d == IDLE_W'(IDLE_CYC)) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= PRIME;
      sync1_q     <= '0;
      sync2_q     <= '0;
      acc_q       <= '0;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
      prime_cnt_q <= '0;
      prev_ab_q   <= '0;
      paddle_q    <= 8'(CENTER);
      dir_q       <= 1'b0;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
      active_q    <= 1'b0;
      idle_q      <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      acc_q       <= acc_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
      prime_cnt_q <= prime_cnt_d;
      prev_ab_q   <= prev_ab_d;
      paddle_q    <= paddle_d;
      dir_q       <= dir_d;
      step_q      <= step_d;
      err_q       <= err_d;
      active_q    <= active_d;
      idle_q      <= idle_d;
    end
  end

  assign bus.paddle     = paddle_q;
  assign bus.dir        = dir_q;
  assign bus.step_pulse = step_q;
  assign bus.err        = err_q;
  assign bus.active     = active_q;
endmodule

// File: tb/tb_quad2paddle.sv
// Directed + randomized bench for quad2paddle against a position-table reference model.
// Honours QUAD_X4_EN the same way as the design build.
module tb_quad2paddle;
  localparam int unsigned FILT_LEN = 4;
  localparam int unsigned STEP     = 2;
  localparam int unsigned CENTER   = 128;
  localparam int unsigned IDLE_CYC = 100;
`ifdef QUAD_X4_EN
  localparam int CYC_PADDLE = 136;
`else
  localparam int CYC_PADDLE = 130;
`endif

  logic clk_sys = 1'b0;
  logic reset;

  quad2paddle_if bus();

  quad2paddle #(
    .FILT_LEN(FILT_LEN),
    .STEP    (STEP),
    .CENTER  (CENTER),
    .IDLE_CYC(IDLE_CYC)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int n_vec = 0;
  int n_bad = 0;
  int n_step_seen = 0;
  int n_err_seen = 0;

  always @(negedge clk_sys) begin
    if (bus.step_pulse === 1'b1) n_step_seen <= n_step_seen + 1;
    if (bus.err === 1'b1)        n_err_seen  <= n_err_seen + 1;
  end

  // Reference model state
  logic [1:0] gray_order [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [1:0] ref_ab;
  int         ref_paddle;
  logic       ref_dir;
  logic       ref_active;

  function automatic int qpos(input logic [1:0] ab);
    for (int i = 0; i < 4; i++) if (gray_order[i] == ab) return i;
    return 0;
  endfunction

  function automatic logic [1:0] next_cw(input logic [1:0] ab);
    return gray_order[(qpos(ab) + 1) % 4];
  endfunction

  function automatic logic [1:0] next_ccw(input logic [1:0] ab);
    return gray_order[(qpos(ab) + 3) % 4];
  endfunction

  function automatic int model_delta(input logic [1:0] from, input logic [1:0] to);
    int d;
    d = (qpos(to) - qpos(from) + 4) % 4;
`ifndef QUAD_X4_EN
    if (to != 2'b00) return 0;
`endif
    if (d == 1) return 1;
    if (d == 3) return -1;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  // Drive a new settled level, hold it, and compare the window against the model.
  task automatic apply_state(input logic [1:0] nxt, input int hold, input bit ctr);
    int d, s0, e0, p;
    bit bad;
    d   = model_delta(ref_ab, nxt);
    bad = ((nxt ^ ref_ab) == 2'b11);
    s0  = n_step_seen;
    e0  = n_err_seen;
    bus.enc_a = nxt[1];
    bus.enc_b = nxt[0];
    if (d != 0) begin
      tick(FILT_LEN + 2);
      check("step_early", 32'(bus.step_pulse), 0);
      if (ctr) bus.center = 1'b1;
      tick(1);
      bus.center = 1'b0;
      check("step_latency", 32'(bus.step_pulse), 1);
      check("active_on_step", 32'(bus.active), 1);
      tick(hold - int'(FILT_LEN + 3));
    end else begin
      tick(hold);
    end
    if (!bad && d != 0) begin
      p = ref_paddle + d * int'(STEP);
      ref_paddle = (p > 255) ? 255 : (p < 0) ? 0 : p;
      ref_dir    = (d > 0);
      ref_active = 1'b1;
    end
    if (ctr) ref_paddle = CENTER;
    ref_ab = nxt;
    check("step_count", n_step_seen - s0, (d != 0 && !bad) ? 1 : 0);
    check("err_count", n_err_seen - e0, bad ? 1 : 0);
    check("paddle", 32'(bus.paddle), ref_paddle);
    check("dir", 32'(bus.dir), 32'(ref_dir));
  endtask

  task automatic run_counts(input bit cw, input int n);
    int cnt;
    logic [1:0] nxt;
    cnt = 0;
    while (cnt < n) begin
      nxt = cw ? next_cw(ref_ab) : next_ccw(ref_ab);
      if (model_delta(ref_ab, nxt) != 0) cnt++;
      apply_state(nxt, int'($urandom_range(8, 14)), 1'b0);
    end
  endtask

  initial begin
    int s0, e0, keep;
    logic [1:0] nxt;

    reset = 1'b1;
    bus.enc_a = 1'b0;
    bus.enc_b = 1'b0;
    bus.center = 1'b0;
    ref_ab = 2'b00;
    ref_paddle = CENTER;
    ref_dir = 1'b0;
    ref_active = 1'b0;

    // Reset state
    tick(3);
    check("rst_paddle", 32'(bus.paddle), CENTER);
    check("rst_dir", 32'(bus.dir), 0);
    check("rst_step", 32'(bus.step_pulse), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_active", 32'(bus.active), 0);
    reset = 1'b0;
    s0 = n_step_seen;
    e0 = n_err_seen;
    tick(2 + FILT_LEN + 6);
    check("prime_no_step", n_step_seen - s0, 0);
    check("prime_no_err", n_err_seen - e0, 0);

    // One full CW cycle, 20 cycles per state
    for (int i = 0; i < 4; i++) apply_state(next_cw(ref_ab), 20, 1'b0);
    check("cycle_paddle", 32'(bus.paddle), CYC_PADDLE);
    check("cycle_dir", 32'(bus.dir), 1);
    check("cycle_active", 32'(bus.active), 1);

    // Saturation at both rails
    run_counts(1'b1, 80);
    check("sat_hi", 32'(bus.paddle), 255);
    run_counts(1'b0, 200);
    check("sat_lo", 32'(bus.paddle), 0);

    // Random walk
    repeat (40) begin
      nxt = $urandom_range(0, 1) ? next_cw(ref_ab) : next_ccw(ref_ab);
      apply_state(nxt, int'($urandom_range(8, 16)), 1'b0);
    end

    // Glitch shorter than the filter
    s0 = n_step_seen;
    e0 = n_err_seen;
    keep = ref_paddle;
    bus.enc_a = ~ref_ab[1];
    tick(3);
    bus.enc_a = ref_ab[1];
    tick(20);
    check("glitch_step", n_step_seen - s0, 0);
    check("glitch_err", n_err_seen - e0, 0);
    check("glitch_paddle", 32'(bus.paddle), keep);

    // Illegal double-phase jump
    keep = ref_paddle;
    apply_state(ref_ab ^ 2'b11, 20, 1'b0);
    check("illegal_paddle", 32'(bus.paddle), keep);

    // Walk to 200, then collide center with a counted CW step
    while (ref_paddle != 200) run_counts(ref_paddle < 200, 1);
    while (model_delta(ref_ab, next_cw(ref_ab)) == 0) apply_state(next_cw(ref_ab), 10, 1'b0);
    apply_state(next_cw(ref_ab), FILT_LEN + 4, 1'b1);
    check("center_win", 32'(bus.paddle), CENTER);
    tick(IDLE_CYC - 2);
    check("idle_still_active", 32'(bus.active), 1);
    tick(1);
    check("idle_drop", 32'(bus.active), 0);

    // Reset between two Gray states mid-rotation
    apply_state(next_cw(ref_ab), 12, 1'b0);
    nxt = next_cw(ref_ab);
    bus.enc_a = nxt[1];
    bus.enc_b = nxt[0];
    tick(3);
    reset = 1'b1;
    tick(1);
    check("midrst_paddle", 32'(bus.paddle), CENTER);
    check("midrst_active", 32'(bus.active), 0);
    check("midrst_dir", 32'(bus.dir), 0);
    check("midrst_step", 32'(bus.step_pulse), 0);
    reset = 1'b0;
    ref_paddle = CENTER;
    ref_dir = 1'b0;
    ref_active = 1'b0;
    ref_ab = nxt;
    s0 = n_step_seen;
    e0 = n_err_seen;
    tick(20);
    check("midrst_absorbed", n_step_seen - s0, 0);
    check("midrst_no_err", n_err_seen - e0, 0);
    apply_state(next_cw(ref_ab), 20, 1'b0);
    apply_state(next_cw(ref_ab), 20, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
